// File: rtl/mode_counter.sv
// -----------------------------------------------------------------------------
// mode_counter
//
// Multi-mode register-counter that sits between the control FSM and the
// display/datapath logic. It holds a WIDTH-bit value and, each rising edge,
// applies one of: hold, increment or decrement by a variable step, rotate
// right/left by fixed distances, or bitwise invert. It can also be preset to
// INIT or loaded from an external value. All outputs are registered.
//
// Build option:
//   MODE_COUNTER_SAT_EN - when defined, inc/dec clamp at the range limits
//                         instead of wrapping modulo 2^WIDTH. In that build
//                         `wrap` pulses on the clamping cycle ("saturated").
//
// Ports:
//   o_clk        in   1       system clock, rising edge
//   reset        in   1       synchronous active-high reset
//   input_pause  in   1       1 = freeze data/zero (wrap forced low)
//   set          in   1       load INIT (beats load_en and op)
//   load_en      in   1       load load_data (beats op)
//   load_data    in   WIDTH   external load value
//   op           in   3       000 hold, 001 inc, 010 dec, 011 rotr,
//                             100 rotl, 101 invert, 110/111 hold
//   step         in   STEP_W  unsigned inc/dec amount
//   data         out  WIDTH   counter value
//   wrap         out  1       one-cycle pulse when an inc/dec crossed the range
//   zero         out  1       high when data == 0
// -----------------------------------------------------------------------------
module mode_counter #(
    parameter int WIDTH  = 12,
    parameter int INIT   = 0,
    parameter int STEP_W = 4,
    parameter int ROT_R  = 1,
    parameter int ROT_L  = 2
) (
    input  logic              o_clk,
    input  logic              reset,
    input  logic              input_pause,
    input  logic              set,
    input  logic              load_en,
    input  logic [WIDTH-1:0]  load_data,
    input  logic [2:0]        op,
    input  logic [STEP_W-1:0] step,
    output logic [WIDTH-1:0]  data,
    output logic              wrap,
    output logic              zero
);

    localparam logic [2:0] OP_HOLD = 3'b000;
    localparam logic [2:0] OP_INC  = 3'b001;
    localparam logic [2:0] OP_DEC  = 3'b010;
    localparam logic [2:0] OP_ROTR = 3'b011;
    localparam logic [2:0] OP_ROTL = 3'b100;
    localparam logic [2:0] OP_INV  = 3'b101;

    // INIT is truncated to the counter width.
    localparam logic [WIDTH-1:0] INIT_V = WIDTH'(INIT);

    // A distance of 0 must behave as hold; the shift form below would OR in
    // a WIDTH-bit shift (all zeros), which already yields the input unchanged,
    // but the explicit branch keeps the intent obvious.
    function automatic logic [WIDTH-1:0] rot_right(input logic [WIDTH-1:0] v);
        if (ROT_R == 0) begin
            return v;
        end else begin
            return (v >> ROT_R) | (v << (WIDTH - ROT_R));
        end
    endfunction

    function automatic logic [WIDTH-1:0] rot_left(input logic [WIDTH-1:0] v);
        if (ROT_L == 0) begin
            return v;
        end else begin
            return (v << ROT_L) | (v >> (WIDTH - ROT_L));
        end
    endfunction

    logic [WIDTH-1:0] data_r;
    logic             wrap_r;
    logic             zero_r;

    logic [WIDTH:0]   step_ext_s;
    logic [WIDTH:0]   sum_s;
    logic [WIDTH:0]   diff_s;
    logic [WIDTH-1:0] next_data_s;
    logic             next_wrap_s;

    // Arithmetic is done one bit wider so bit WIDTH is the carry (inc) or
    // borrow (dec); the borrow bit is set exactly when step > data.
    assign step_ext_s = {{(WIDTH + 1 - STEP_W){1'b0}}, step};
    assign sum_s      = {1'b0, data_r} + step_ext_s;
    assign diff_s     = {1'b0, data_r} - step_ext_s;

    // Next-state selection for the run (not paused, not reset) case.
    always_comb begin
        next_data_s = data_r;
        next_wrap_s = 1'b0;
        if (set) begin
            next_data_s = INIT_V;
        end else if (load_en) begin
            next_data_s = load_data;
        end else begin
            case (op)
                OP_HOLD: begin
                    next_data_s = data_r;
                end
                OP_INC: begin
                    next_wrap_s = sum_s[WIDTH];
`ifdef MODE_COUNTER_SAT_EN
                    if (sum_s[WIDTH]) begin
                        next_data_s = {WIDTH{1'b1}};
                    end else begin
                        next_data_s = sum_s[WIDTH-1:0];
                    end
`else
                    next_data_s = sum_s[WIDTH-1:0];
`endif
                end
                OP_DEC: begin
                    next_wrap_s = diff_s[WIDTH];
`ifdef MODE_COUNTER_SAT_EN
                    if (diff_s[WIDTH]) begin
                        next_data_s = {WIDTH{1'b0}};
                    end else begin
                        next_data_s = diff_s[WIDTH-1:0];
                    end
`else
                    next_data_s = diff_s[WIDTH-1:0];
`endif
                end
                OP_ROTR: begin
                    next_data_s = rot_right(data_r);
                end
                OP_ROTL: begin
                    next_data_s = rot_left(data_r);
                end
                OP_INV: begin
                    next_data_s = ~data_r;
                end
                default: begin
                    next_data_s = data_r;
                end
            endcase
        end
    end

    // State registers: reset, then pause (hold, wrap low), then update.
    always_ff @(posedge o_clk) begin
        if (reset) begin
            data_r <= {WIDTH{1'b0}};
            wrap_r <= 1'b0;
            zero_r <= 1'b1;
        end else if (input_pause) begin
            data_r <= data_r;
            wrap_r <= 1'b0;
            zero_r <= zero_r;
        end else begin
            data_r <= next_data_s;
            wrap_r <= next_wrap_s;
            zero_r <= (next_data_s == {WIDTH{1'b0}});
        end
    end

    assign data = data_r;
    assign wrap = wrap_r;
    assign zero = zero_r;

endmodule

// File: tb/tb_mode_counter.sv
// Self-checking bench for mode_counter (WIDTH=12, INIT=0x0A5, STEP_W=4,
// ROT_R=1, ROT_L=2). Directed cases from the block's test plan followed by
// randomized cycles, all checked against an integer-arithmetic reference model.
module tb_mode_counter;

    localparam int W      = 12;
    localparam int MOD    = 4096;
    localparam int MAXV   = 4095;
    localparam int INIT_V = 'h0A5;
    localparam int RR     = 1;
    localparam int RL     = 2;

    logic        o_clk;
    logic        reset;
    logic        input_pause;
    logic        set;
    logic        load_en;
    logic [11:0] load_data;
    logic [2:0]  op;
    logic [3:0]  step;
    logic [11:0] data;
    logic        wrap;
    logic        zero;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int md = 0;
    int mw = 0;
    int mz = 1;

    mode_counter #(
        .WIDTH (12),
        .INIT  ('h0A5),
        .STEP_W(4),
        .ROT_R (1),
        .ROT_L (2)
    ) dut (
        .o_clk      (o_clk),
        .reset      (reset),
        .input_pause(input_pause),
        .set        (set),
        .load_en    (load_en),
        .load_data  (load_data),
        .op         (op),
        .step       (step),
        .data       (data),
        .wrap       (wrap),
        .zero       (zero)
    );

    initial o_clk = 1'b0;
    always #5 o_clk = ~o_clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, advance the model, then check after the edge.
    task automatic cyc(input bit r, input bit p, input bit s, input bit l,
                       input int ld, input int o, input int st);
        int t;
        reset       = r;
        input_pause = p;
        set         = s;
        load_en     = l;
        load_data   = ld[11:0];
        op          = o[2:0];
        step        = st[3:0];

        if (r) begin
            md = 0; mw = 0;
        end else if (p) begin
            mw = 0;
        end else if (s) begin
            md = INIT_V; mw = 0;
        end else if (l) begin
            md = ld % MOD; mw = 0;
        end else begin
            mw = 0;
            case (o)
                1: begin
                    t = md + st;
                    if (t > MAXV) begin
                        mw = 1;
`ifdef MODE_COUNTER_SAT_EN
                        md = MAXV;
`else
                        md = t - MOD;
`endif
                    end else md = t;
                end
                2: begin
                    if (st > md) begin
                        mw = 1;
`ifdef MODE_COUNTER_SAT_EN
                        md = 0;
`else
                        md = md - st + MOD;
`endif
                    end else md = md - st;
                end
                3: if (RR != 0) md = md / (2 ** RR) + (md % (2 ** RR)) * (2 ** (W - RR));
                4: if (RL != 0) md = (md % (2 ** (W - RL))) * (2 ** RL) + md / (2 ** (W - RL));
                5: md = MAXV - md;
                default: ;
            endcase
        end
        if (r || !p) mz = (md == 0) ? 1 : 0;

        @(posedge o_clk);
        #1;
        chk("data", int'(data), md);
        chk("wrap", int'(wrap), mw);
        chk("zero", int'(zero), mz);
    endtask

    initial begin
        reset = 1'b1; input_pause = 1'b0; set = 1'b0; load_en = 1'b0;
        load_data = 12'h000; op = 3'b000; step = 4'h0;

        // 1: reset, then set
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 'h123, 1, 7);
        chk("t1_rst_data", int'(data), 0);
        chk("t1_rst_zero", int'(zero), 1);
        cyc(0, 0, 1, 0, 0, 0, 0);
        chk("t1_set_data", int'(data), 'h0A5);
        chk("t1_set_zero", int'(zero), 0);

        // 2: overflow on inc, then wrap drops after one cycle
        cyc(0, 0, 0, 1, 'hFFE, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 3);
`ifdef MODE_COUNTER_SAT_EN
        chk("t2_data", int'(data), 'hFFF);
`else
        chk("t2_data", int'(data), 'h001);
`endif
        chk("t2_wrap", int'(wrap), 1);
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("t2_wrap_pulse", int'(wrap), 0);
        // back-to-back wrapping incs
        cyc(0, 0, 0, 1, 'hFFF, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 15);
        cyc(0, 0, 0, 0, 0, 1, 15);

        // 3: dec to zero then underflow
        cyc(0, 0, 0, 1, 'h002, 0, 0);
        cyc(0, 0, 0, 0, 0, 2, 2);
        chk("t3_zero_data", int'(data), 0);
        chk("t3_zero_flag", int'(zero), 1);
        chk("t3_zero_wrap", int'(wrap), 0);
        cyc(0, 0, 0, 0, 0, 2, 1);
`ifdef MODE_COUNTER_SAT_EN
        chk("t3_uf_data", int'(data), 0);
`else
        chk("t3_uf_data", int'(data), 'hFFF);
`endif
        chk("t3_uf_wrap", int'(wrap), 1);
        cyc(0, 0, 0, 0, 0, 2, 0);  // step 0: no change, no wrap

        // 4: rotations and invert
        cyc(0, 0, 0, 1, 'h801, 0, 0);
        cyc(0, 0, 0, 0, 0, 3, 9);
        chk("t4_rotr", int'(data), 'hC00);
        cyc(0, 0, 0, 0, 0, 4, 9);
        chk("t4_rotl", int'(data), 'h003);
        cyc(0, 0, 0, 0, 0, 5, 9);
        chk("t4_inv", int'(data), 'hFFC);
        chk("t4_wrap", int'(wrap), 0);

        // 5: pause swallows commands
        cyc(0, 0, 0, 1, 'h0A5, 0, 0);
        cyc(0, 1, 0, 0, 0, 1, 5);
        cyc(0, 1, 1, 0, 0, 1, 5);
        cyc(0, 1, 0, 1, 'h777, 1, 5);
        cyc(0, 1, 0, 0, 0, 1, 5);
        chk("t5_pause", int'(data), 'h0A5);
        cyc(0, 0, 0, 0, 0, 1, 5);
        chk("t5_release", int'(data), 'h0AA);

        // 6: reset beats set/load; set beats load and op
        cyc(1, 0, 1, 1, 'h321, 1, 3);
        chk("t6_rst", int'(data), 0);
        cyc(0, 0, 1, 1, 'h321, 2, 3);
        chk("t6_set", int'(data), 'h0A5);

        // Randomized cycles against the model
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(0, 40) == 0),
                ($urandom_range(0, 7) == 0),
                ($urandom_range(0, 15) == 0),
                ($urandom_range(0, 9) == 0),
                int'($urandom_range(0, MAXV)),
                int'($urandom_range(0, 7)),
                int'($urandom_range(0, 15)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
